// File: rtl/serial_cmd_rx.sv
// Asynchronous serial frame receiver: start, DATA_WIDTH data bits LSB first,
// parity, stop. Delivers the accepted word plus parity status; framing faults are flagged separately.
module serial_cmd_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  p_error,
    output logic                  framing_error,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FLUSH    = CW'(2);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
    localparam logic          PAR_ODD  = (PARITY_ODD != 0);

    localparam logic [2:0] ST_RECOVER = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_START   = 3'd2;
    localparam logic [2:0] ST_DATA    = 3'd3;
    localparam logic [2:0] ST_PARITY  = 3'd4;
    localparam logic [2:0] ST_STOP    = 3'd5;
    localparam logic [2:0] ST_BREAK   = 3'd6;

    logic                  sync1_q, sync2_q;
    logic                  rx_s;
    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  dv_q, dv_d;
    logic                  fe_q, fe_d;

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            ST_RECOVER: begin
                // The synchroniser's reset value is not a real line sample, so
                // wait until it has been flushed before trusting rx_s high.
                if (cnt_q == FLUSH) begin
                    cnt_d = cnt_q;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        perr_d  = ((^shift_q) ^ par_q) != PAR_ODD;
                        dv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RECOVER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_RECOVER;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    assign data_out      = data_q;
    assign p_error       = perr_q;
    assign data_valid    = dv_q;
    assign framing_error = fe_q;
    assign busy          = (state_q == ST_START) || (state_q == ST_DATA) ||
                           (state_q == ST_PARITY) || (state_q == ST_STOP);

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx: frames are bit-banged cycle-accurately and
// pulses are timestamped against the expected stop-sample edge.
module tb_serial_cmd_rx;

    localparam int N  = 16;
    localparam int H  = N / 2;
    // pin fall -> IDLE sees it (3 edges) -> start sample (+H) -> stop sample (+10N)
    localparam int DV_LAT = 3 + H + 10 * N;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       p_error;
    logic       framing_error;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    int dv_count   = 0;
    int fe_count   = 0;
    int fe_cyc     = -1;
    int overlap    = 0;
    int long_pulse = 0;
    int dv_cyc_q[$];
    logic [7:0] dv_word_q[$];
    logic prev_dv = 1'b0;
    logic prev_fe = 1'b0;

    serial_cmd_rx #(
        .CLKS_PER_BIT(N),
        .DATA_WIDTH  (8),
        .PARITY_ODD  (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .p_error      (p_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_count++;
            dv_cyc_q.push_back(cyc);
            dv_word_q.push_back(data_out);
        end
        if (framing_error) begin
            fe_count++;
            fe_cyc = cyc;
        end
        if (data_valid && framing_error) overlap++;
        if ((data_valid && prev_dv) || (framing_error && prev_fe)) long_pulse++;
        prev_dv = data_valid;
        prev_fe = framing_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int last_dv_cyc(input int back);
        if (dv_cyc_q.size() > back) return dv_cyc_q[dv_cyc_q.size() - 1 - back];
        return -1;
    endfunction

    function automatic logic [7:0] last_dv_word();
        if (dv_word_q.size() > 0) return dv_word_q[dv_word_q.size() - 1];
        return 8'hxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(N);
    endtask

    // Entered at posedge+1; c0 is the cycle stamp of the edge before the pin falls.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, output int c0);
        c0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
    endtask

    task automatic check_frame(input string tag, input int c0, input int exp_dv,
                               input logic [7:0] exp_word, input logic exp_perr);
        check({tag, "_dv_count"}, dv_count, exp_dv);
        check({tag, "_dv_cycle"}, last_dv_cyc(0), c0 + DV_LAT);
        check({tag, "_dv_word"}, last_dv_word(), exp_word);
        check({tag, "_data_out"}, data_out, exp_word);
        check({tag, "_p_error"}, p_error, exp_perr);
    endtask

    initial begin
        int c0, c1, c2, dv0, fe0;
        rst_n = 1'b0;
        rx    = 1'b1;
        idle(3);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_p_error", p_error, 1'b0);
        check("rst_framing_error", framing_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        idle(10);

        // 0x35 has four ones: even parity bit 0 is correct
        send_frame(8'h35, 1'b0, 1'b1, c0);
        idle(4);
        check_frame("f35_ok", c0, 1, 8'h35, 1'b0);
        check("f35_ok_no_fe", fe_count, 0);

        send_frame(8'h35, 1'b1, 1'b1, c0);
        idle(4);
        check_frame("f35_bad_par", c0, 2, 8'h35, 1'b1);

        // Short glitch: start bit rejected at the half-bit point
        dv0 = dv_count;
        fe0 = fe_count;
        rx  = 1'b0;
        idle(5);
        check("glitch_busy_high", busy, 1'b1);
        rx = 1'b1;
        idle(20);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_dv", dv_count, dv0);
        check("glitch_no_fe", fe_count, fe0);
        check("glitch_data_out", data_out, 8'h35);
        check("glitch_p_error", p_error, 1'b1);

        // Reset during data bit 3 with the line held low
        rx = 1'b0;
        idle(70);
        check("midrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        idle(1);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_p_error", p_error, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data_valid", data_valid, 1'b0);
        check("midrst_framing_error", framing_error, 1'b0);
        rst_n = 1'b1;
        idle(3 * N);
        check("midrst_low_busy", busy, 1'b0);
        check("midrst_low_no_dv", dv_count, 2);
        check("midrst_low_no_fe", fe_count, 0);
        rx = 1'b1;
        idle(10);
        send_frame(8'h3C, 1'b0, 1'b1, c0);
        idle(4);
        check_frame("f3c_after_rst", c0, 3, 8'h3C, 1'b0);

        send_frame(8'h0F, 1'b0, 1'b1, c0);
        idle(4);
        check_frame("f0f", c0, 4, 8'h0F, 1'b0);

        send_frame(8'h35, 1'b0, 1'b1, c0);
        idle(4);
        check_frame("f35_pre_fe", c0, 5, 8'h35, 1'b0);

        // 0xA2 with stop bit 0; line stays low afterwards
        send_frame(8'hA2, 1'b1, 1'b0, c0);
        idle(3 * N);
        check("fe_count", fe_count, 1);
        check("fe_cycle", fe_cyc, c0 + DV_LAT);
        check("fe_no_dv", dv_count, 5);
        check("fe_data_out", data_out, 8'h35);
        check("fe_p_error", p_error, 1'b0);
        check("fe_break_busy", busy, 1'b0);
        rx = 1'b1;
        idle(10);

        // Back-to-back: 0x01 needs parity 1, 0x3F (six ones) parity 0
        send_frame(8'h01, 1'b1, 1'b1, c1);
        send_frame(8'h3F, 1'b0, 1'b1, c2);
        idle(4);
        check("b2b_dv_count", dv_count, 7);
        check("b2b_first_cycle", last_dv_cyc(1), c1 + DV_LAT);
        check("b2b_spacing", last_dv_cyc(0) - last_dv_cyc(1), 11 * N);
        check("b2b_first_word", dv_word_q[5], 8'h01);
        check_frame("b2b_second", c2, 7, 8'h3F, 1'b0);

        check("pulse_overlap", overlap, 0);
        check("pulse_width", long_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_cmd_rx.md
# serial_cmd_rx

Serial frame receiver that sits directly upstream of the control FSM. It deserialises one asynchronous frame per command: start bit, DATA_WIDTH data bits LSB first, one parity bit, one stop bit. It presents the word on `data_out`, with `data_out[5:0]` feeding the controller's `cmd_in`, and drives the `p_error` flag the controller uses to invalidate data selections. Framing faults are reported separately and never produce a data word.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4.
- `DATA_WIDTH`, 8: data bits per frame; 6..16.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `data_out`  out  DATA_WIDTH  last accepted word; bits [5:0] drive `cmd_in`.
- `data_valid`  out  1  one-cycle pulse when `data_out`/`p_error` update.
- `p_error`  out  1  parity mismatch of last accepted word; held with `data_out`.
- `framing_error`  out  1  one-cycle pulse when a stop bit samples 0.
- `busy`  out  1  high while a frame is being received (START..STOP).

## Operation
- `rx` passes through a 2-FF synchroniser (both flops reset to 1). All decisions use `rx_s`, the second-flop output.
- States: RECOVER, IDLE, START, DATA, PARITY, STOP, BREAK. Reset state is RECOVER.
- RECOVER/BREAK: wait for `rx_s` = 1, then go to IDLE. This prevents resynchronising mid-frame after reset or a framing fault.
- IDLE: `rx_s` = 0 → START, bit counter cleared, bit index cleared.
- START: at half-bit point, `rx_s` = 0 → DATA; `rx_s` = 1 → IDLE (glitch rejected, no outputs change).
- DATA: sample every CLKS_PER_BIT cycles into a shift register, LSB first. After DATA_WIDTH samples → PARITY.
- PARITY: sample the parity bit after one further bit period → STOP.
- STOP: sample after one further bit period.
  - `rx_s` = 1 → accept: load `data_out`; set `p_error` = (XOR of data bits XOR parity bit) ≠ PARITY_ODD; pulse `data_valid`; → IDLE.
  - `rx_s` = 0 → pulse `framing_error`; `data_out`/`p_error` unchanged; no `data_valid`; → BREAK.
- `busy` = 1 in START, DATA, PARITY, STOP; 0 otherwise.
- Reset values: `data_out` 0, `data_valid` 0, `p_error` 0, `framing_error` 0, `busy` 0.
- `rst_n` low mid-frame: on the next edge, all outputs go to reset values, state → RECOVER, partial word discarded.
- `data_valid` and `framing_error` are never high in the same cycle. Neither pulse lasts more than one cycle.

## Timing
- Let t0 = the edge where IDLE sees `rx_s` = 0 (2–3 cycles after the pin falls). H = CLKS_PER_BIT/2, N = CLKS_PER_BIT.
- Start sample at t0+H. Data bit i sampled at t0+H+(i+1)·N. Parity at t0+H+(DATA_WIDTH+1)·N. Stop at t0+H+(DATA_WIDTH+2)·N.
- `data_valid`/`framing_error` are high for the single cycle after the stop-sample edge. State is IDLE/BREAK in that same cycle.
- Back-to-back frames: a start bit beginning immediately after the stop bit must be received; IDLE is re-entered within 1 cycle of the stop sample.
- `data_out` and `p_error` are stable from the `data_valid` cycle until the next `data_valid`. The controller may sample them on any later edge.

## Test plan
- Defaults, frame 0x35 with parity 0, stop 1 → `data_valid` one cycle at t0+H+10N+1; `data_out` = 0x35, `p_error` = 0, `framing_error` never high.
- Frame 0x35 with parity bit 1 → `data_valid` pulse, `data_out` = 0x35, `p_error` = 1. Then 0x0F with parity 0 → `p_error` returns to 0.
- After accepting 0x35, send 0xA2 with stop bit 0 → `framing_error` one-cycle pulse, no `data_valid`, `data_out` stays 0x35. Next frame is not detected until `rx` has returned high.
- `rx` low for 5 cycles then high (below H+sync) → state returns IDLE, `busy` drops, no pulses, outputs unchanged.
- `rst_n` low for 1 cycle during data bit 3 while `rx` is held low → all outputs 0 next cycle; no frame detected until `rx` goes high. A following clean frame 0x3C is received correctly.
- Two frames 0x01 and 0x3F back-to-back with no idle gap → two `data_valid` pulses exactly 11·N cycles apart, with correct words and `p_error` = 0.
